decodificador_pt2272: RTL and testbench

//  Receive end of the PT2262/PT2272 link: decodes serial cod_i frames (A0..A7, D3..D0, sync) produced by the

---
 rtl/decodificador_pt2272.sv | 221 ++++++++++++++++++++++
 tb/tb_decodificador_pt2272.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_pt2272.sv
// PT2272-style receiver: measures pulse widths on cod_i, rebuilds the
// 12 tri-state symbols and latches D[3:0] after two matching good frames.
module decodificador_pt2272 #(
    parameter int ALPHA_CLKS = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cod_i,
    input  logic [7:0] addr_val,
    input  logic [7:0] addr_f,
    output logic [3:0] d_o,
    output logic       dv,
    output logic       frame_ok,
    output logic       sync_det
);

    localparam logic [16:0] SHORT_MIN = 17'(2 * ALPHA_CLKS);
    localparam logic [16:0] LONG_MIN  = 17'(8 * ALPHA_CLKS);
    localparam logic [16:0] LONG_MAX  = 17'(16 * ALPHA_CLKS);
    localparam logic [16:0] SYNC_MIN  = 17'(64 * ALPHA_CLKS);
    localparam logic [16:0] SYNC_MAX  = 17'(192 * ALPHA_CLKS);

    typedef enum logic [1:0] {
        HUNT,
        SYNC_LOW,
        RX_HIGH,
        RX_LOW
    } state_t;

    state_t      state_q;
    logic        cod_s1_q, cod_s2_q, cod_s3_q;
    logic [15:0] cnt_q;
    logic [4:0]  half_idx_q;
    logic [23:0] halves_q;
    logic        high_s_q, high_l_q;
    logic [3:0]  d_q;
    logic        dv_q, frame_ok_q, sync_det_q;
    logic        hist_v_q;
    logic [3:0]  hist_d_q;

    logic        edge_w, fall_w, rise_w;
    logic [16:0] wid;
    logic        is_glitch, is_s, is_l, is_over;
    logic        pair_s, pair_l, bad_sym;
    logic [4:0]  idx_m1;
    logic        hunt_sync, start_rx, to_low, store;
    logic        err_ev, tmo_ev, fend_ev;
    logic        addr_ok_d, data_ok_d;
    logic [3:0]  data_d;

    assign d_o      = d_q;
    assign dv       = dv_q;
    assign frame_ok = frame_ok_q;
    assign sync_det = sync_det_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cod_s1_q <= 1'b0;
            cod_s2_q <= 1'b0;
            cod_s3_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cod_s1_q <= cod_i;
            cod_s2_q <= cod_s1_q;
            cod_s3_q <= cod_s2_q;
            if (edge_w)
                cnt_q <= '0;
            else if (cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    // wid is the length of the current level including this cycle
    always_comb begin
        edge_w    = cod_s2_q ^ cod_s3_q;
        fall_w    = edge_w && !cod_s2_q;
        rise_w    = edge_w && cod_s2_q;
        wid       = {1'b0, cnt_q} + 17'd1;
        is_glitch = wid < SHORT_MIN;
        is_s      = !is_glitch && (wid < LONG_MIN);
        is_l      = (wid >= LONG_MIN) && (wid <= LONG_MAX);
        is_over   = wid > LONG_MAX;
        pair_s    = high_s_q && is_l;
        pair_l    = high_l_q && is_s;
        idx_m1    = half_idx_q - 5'd1;
        bad_sym   = half_idx_q[0] && halves_q[idx_m1] && pair_s;
    end

    always_comb begin
        addr_ok_d = 1'b1;
        data_ok_d = 1'b1;
        data_d    = '0;
        for (int i = 0; i < 8; i++) begin
            if (addr_f[i])
                addr_ok_d &= !halves_q[2*i] && halves_q[2*i+1];
            else
                addr_ok_d &= (halves_q[2*i] == addr_val[i])
                          && (halves_q[2*i+1] == addr_val[i]);
        end
        for (int k = 0; k < 4; k++) begin
            if (halves_q[16+2*k] != halves_q[17+2*k])
                data_ok_d = 1'b0;
            data_d[3-k] = halves_q[16+2*k];
        end
    end

    always_comb begin
        hunt_sync = 1'b0;
        start_rx  = 1'b0;
        to_low    = 1'b0;
        store     = 1'b0;
        err_ev    = 1'b0;
        tmo_ev    = 1'b0;
        fend_ev   = 1'b0;
        unique case (state_q)
            HUNT: begin
                hunt_sync = !cod_s2_q && !edge_w && high_s_q
                         && (wid == SYNC_MIN);
            end
            SYNC_LOW: begin
                if (rise_w)
                    start_rx = 1'b1;
                else if (wid == SYNC_MAX)
                    tmo_ev = 1'b1;
            end
            RX_HIGH: begin
                if (fall_w) begin
                    if (is_glitch || is_over)
                        err_ev = 1'b1;
                    else
                        to_low = 1'b1;
                end else if (cod_s2_q && is_over) begin
                    err_ev = 1'b1;
                end
            end
            RX_LOW: begin
                if (half_idx_q < 5'd24) begin
                    if (rise_w) begin
                        if ((pair_s || pair_l) && !bad_sym)
                            store = 1'b1;
                        else
                            err_ev = 1'b1;
                    end else if (is_over) begin
                        err_ev = 1'b1;
                    end
                end else if (rise_w) begin
                    err_ev = 1'b1;
                end else if (wid == SYNC_MIN) begin
                    if (high_s_q)
                        fend_ev = 1'b1;
                    else
                        err_ev = 1'b1;
                end
            end
            default: err_ev = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            half_idx_q <= '0;
            halves_q   <= '0;
            high_s_q   <= 1'b0;
            high_l_q   <= 1'b0;
            d_q        <= '0;
            dv_q       <= 1'b0;
            frame_ok_q <= 1'b0;
            sync_det_q <= 1'b0;
            hist_v_q   <= 1'b0;
            hist_d_q   <= '0;
        end else begin
            frame_ok_q <= 1'b0;
            sync_det_q <= 1'b0;
            if (fall_w) begin
                high_s_q <= is_s;
                high_l_q <= is_l;
            end
            if (hunt_sync) begin
                sync_det_q <= 1'b1;
                state_q    <= SYNC_LOW;
            end
            if (start_rx) begin
                half_idx_q <= '0;
                state_q    <= RX_HIGH;
            end
            if (to_low)
                state_q <= RX_LOW;
            if (store) begin
                halves_q[half_idx_q] <= pair_l;
                half_idx_q           <= half_idx_q + 5'd1;
                state_q              <= RX_HIGH;
            end
            if (err_ev || tmo_ev) begin
                dv_q     <= 1'b0;
                hist_v_q <= 1'b0;
                state_q  <= HUNT;
            end
            // the terminating sync also opens the next frame
            if (fend_ev) begin
                sync_det_q <= 1'b1;
                state_q    <= SYNC_LOW;
                if (addr_ok_d && data_ok_d) begin
                    frame_ok_q <= 1'b1;
                    hist_v_q   <= 1'b1;
                    hist_d_q   <= data_d;
                    if (hist_v_q && (hist_d_q == data_d)) begin
                        d_q  <= data_d;
                        dv_q <= 1'b1;
                    end else begin
                        dv_q <= 1'b0;
                    end
                end else begin
                    dv_q     <= 1'b0;
                    hist_v_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decodificador_pt2272.sv
// Directed bench for decodificador_pt2272: frame table plus glitch,
// timeout and mid-frame reset sequences, using a short oscillator period.
`timescale 1ns/1ps
module tb_decodificador_pt2272;

    localparam int A        = 4;
    localparam int SYNC_MAX = 192 * A;

    logic       clk = 1'b0;
    logic       reset;
    logic       cod_i;
    logic [7:0] addr_val, addr_f;
    logic [3:0] d_o;
    logic       dv, frame_ok, sync_det;

    int nvec = 0;
    int nfail = 0;
    int fok_cnt = 0;
    int sd_cnt = 0;
    int dbl_cnt = 0;
    bit fok_p = 1'b0;
    bit sd_p = 1'b0;
    int f0, s0;

    decodificador_pt2272 #(.ALPHA_CLKS(A)) dut (
        .clk      (clk),
        .reset    (reset),
        .cod_i    (cod_i),
        .addr_val (addr_val),
        .addr_f   (addr_f),
        .d_o      (d_o),
        .dv       (dv),
        .frame_ok (frame_ok),
        .sync_det (sync_det)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_ok) fok_cnt++;
        if (sync_det) sd_cnt++;
        if ((frame_ok && fok_p) || (sync_det && sd_p)) dbl_cnt++;
        fok_p = frame_ok;
        sd_p  = sync_det;
    end

    typedef struct {
        logic [7:0] cv, cf, ev, ef;
        logic [3:0] dd, df;
        int         fok;
        logic       dv_e;
        logic [3:0] d_e;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        cod_i = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_half(input bit l);
        if (l) begin
            hold(1'b1, 12*A);
            hold(1'b0, 4*A);
        end else begin
            hold(1'b1, 4*A);
            hold(1'b0, 12*A);
        end
    endtask

    task automatic send_sym(input bit f, input bit v, input bit g);
        if (g) begin
            hold(1'b1, 4*A);
            hold(1'b0, 5*A);
            hold(1'b1, A);
            hold(1'b0, 6*A);
        end else begin
            send_half(f ? 1'b0 : v);
        end
        send_half(f ? 1'b1 : v);
    endtask

    task automatic send_sync();
        hold(1'b1, 4*A);
        hold(1'b0, 124*A);
    endtask

    task automatic send_body(input logic [7:0] ev, input logic [7:0] ef,
                             input logic [3:0] dd, input logic [3:0] df,
                             input bit glitch, input int nsym);
        for (int j = 0; j < 12; j++) begin
            if (j < nsym) begin
                if (j < 8)
                    send_sym(ef[j], ev[j], glitch && (j == 2));
                else
                    send_sym(df[11-j], dd[11-j], 1'b0);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] ev, input logic [7:0] ef,
                              input logic [3:0] dd, input logic [3:0] df,
                              input bit glitch);
        send_body(ev, ef, dd, df, glitch, 12);
        send_sync();
    endtask

    task automatic snap();
        f0 = fok_cnt;
        s0 = sd_cnt;
    endtask

    initial begin
        tbl[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 4'b1010, 4'h0, 1, 1'b0, 4'h0};
        tbl[1]  = '{8'h00, 8'h00, 8'h00, 8'h00, 4'b1010, 4'h0, 1, 1'b1, 4'hA};
        tbl[2]  = '{8'h08, 8'h00, 8'h00, 8'h00, 4'b1010, 4'h0, 0, 1'b0, 4'hA};
        tbl[3]  = '{8'h08, 8'h00, 8'h00, 8'h00, 4'b1010, 4'h0, 0, 1'b0, 4'hA};
        tbl[4]  = '{8'h00, 8'h20, 8'h00, 8'h20, 4'b0110, 4'h0, 1, 1'b0, 4'hA};
        tbl[5]  = '{8'h00, 8'h20, 8'h00, 8'h20, 4'b0110, 4'h0, 1, 1'b1, 4'h6};
        tbl[6]  = '{8'h00, 8'h20, 8'h00, 8'h20, 4'b0110, 4'h4, 0, 1'b0, 4'h6};
        tbl[7]  = '{8'hA5, 8'h00, 8'hA5, 8'h00, 4'b1010, 4'h0, 1, 1'b0, 4'h6};
        tbl[8]  = '{8'hA5, 8'h00, 8'hA5, 8'h00, 4'b1010, 4'h0, 1, 1'b1, 4'hA};
        tbl[9]  = '{8'hA5, 8'h00, 8'hA5, 8'h00, 4'b0101, 4'h0, 1, 1'b0, 4'hA};
        tbl[10] = '{8'hA5, 8'h00, 8'hA5, 8'h00, 4'b0101, 4'h0, 1, 1'b1, 4'h5};
        tbl[11] = '{8'h3C, 8'h81, 8'h3C, 8'h81, 4'b1111, 4'h0, 1, 1'b0, 4'h5};
        tbl[12] = '{8'h3C, 8'h81, 8'h3C, 8'h81, 4'b1111, 4'h0, 1, 1'b1, 4'hF};
        tbl[13] = '{8'h3C, 8'h81, 8'h3C, 8'h00, 4'b1111, 4'h0, 0, 1'b0, 4'hF};

        reset    = 1'b1;
        cod_i    = 1'b0;
        addr_val = 8'h00;
        addr_f   = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_d_o", d_o, 0);
        chk("rst_dv", dv, 0);
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_sync_det", sync_det, 0);
        reset = 1'b0;
        hold(1'b0, 10);

        snap();
        send_sync();
        chk("first_sync", sd_cnt - s0, 1);

        for (int r = 0; r < 14; r++) begin
            addr_val = tbl[r].cv;
            addr_f   = tbl[r].cf;
            snap();
            send_frame(tbl[r].ev, tbl[r].ef, tbl[r].dd, tbl[r].df, 1'b0);
            chk($sformatf("row%0d_frame_ok", r), fok_cnt - f0, tbl[r].fok);
            chk($sformatf("row%0d_sync_det", r), sd_cnt - s0, 1);
            chk($sformatf("row%0d_dv", r), dv, tbl[r].dv_e);
            chk($sformatf("row%0d_d_o", r), d_o, tbl[r].d_e);
        end

        addr_val = 8'h00;
        addr_f   = 8'h00;
        send_frame(8'h00, 8'h00, 4'b0011, 4'h0, 1'b0);
        send_frame(8'h00, 8'h00, 4'b0011, 4'h0, 1'b0);
        chk("pre_glitch_dv", dv, 1);
        chk("pre_glitch_d_o", d_o, 4'h3);

        snap();
        send_frame(8'h00, 8'h00, 4'b0011, 4'h0, 1'b1);
        chk("glitch_dv", dv, 0);
        chk("glitch_frame_ok", fok_cnt - f0, 0);
        chk("glitch_hunt_sync", sd_cnt - s0, 1);

        snap();
        send_frame(8'h00, 8'h00, 4'b1100, 4'h0, 1'b0);
        chk("regain1_frame_ok", fok_cnt - f0, 1);
        chk("regain1_dv", dv, 0);
        send_frame(8'h00, 8'h00, 4'b1100, 4'h0, 1'b0);
        chk("regain2_dv", dv, 1);
        chk("regain2_d_o", d_o, 4'hC);

        send_body(8'h00, 8'h00, 4'b1100, 4'h0, 1'b0, 12);
        hold(1'b1, 4*A);
        hold(1'b0, SYNC_MAX);
        chk("tmo_before_dv", dv, 1);
        hold(1'b0, 3);
        chk("tmo_after_dv", dv, 0);
        chk("tmo_d_o_hold", d_o, 4'hC);

        send_sync();
        send_frame(8'h00, 8'h00, 4'b1001, 4'h0, 1'b0);
        send_frame(8'h00, 8'h00, 4'b1001, 4'h0, 1'b0);
        chk("pre_rst_dv", dv, 1);
        snap();
        send_body(8'h00, 8'h00, 4'b1001, 4'h0, 1'b0, 6);
        reset = 1'b1;
        hold(1'b0, 20);
        chk("midrst_d_o", d_o, 0);
        chk("midrst_dv", dv, 0);
        reset = 1'b0;
        hold(1'b0, 50);
        chk("midrst_no_fok", fok_cnt - f0, 0);
        chk("midrst_no_sync", sd_cnt - s0, 0);

        send_sync();
        snap();
        send_frame(8'h00, 8'h00, 4'b0110, 4'h0, 1'b0);
        chk("post_rst1_frame_ok", fok_cnt - f0, 1);
        chk("post_rst1_dv", dv, 0);
        send_frame(8'h00, 8'h00, 4'b0110, 4'h0, 1'b0);
        chk("post_rst2_dv", dv, 1);
        chk("post_rst2_d_o", d_o, 4'h6);

        chk("no_double_pulse", dbl_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
